// File: rtl/addr_decoding_pkg.sv
// addr_decoding_pkg: shared data-memory map for the core and the address decoder
package addr_decoding_pkg;
  typedef logic [31:0] addr_t;
  localparam addr_t DMEM_BASE = 32'h0000_1000;
  localparam addr_t DMEM_SIZE = 32'h0000_1000;
endpackage

// File: rtl/addr_window_cmp.sv
// addr_window_cmp: combinational hit test and window-relative offset for one address window
module addr_window_cmp
  import addr_decoding_pkg::*;
#(
  parameter addr_t BASE = DMEM_BASE,
  parameter addr_t SIZE = DMEM_SIZE
) (
  input  addr_t addr,
  output logic  hit,
  output addr_t off
);
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = {1'b0, BASE} + {1'b0, SIZE};
  generate
    if (SIZE < 32'd4 || (SIZE & (SIZE - 32'd1)) != 32'd0) begin : g_size_chk
      $error("addr_window_cmp: SIZE must be a power of two >= 4");
    end
    if ((BASE & (SIZE - 32'd1)) != 32'd0) begin : g_align_chk
      $error("addr_window_cmp: BASE must be aligned to SIZE");
    end
  endgenerate
  // 33-bit bounds keep a window ending at 2^32 from wrapping
  always_comb begin
    hit = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
    off = hit ? addr - BASE : '0;
  end
endmodule

// File: rtl/addr_decoding.sv
// addr_decoding: data-memory chip select, write gating and offset for the core load/store port
module addr_decoding
  import addr_decoding_pkg::*;
#(
  parameter addr_t BASE_ADDR = DMEM_BASE,
  parameter addr_t WIN_SIZE  = DMEM_SIZE,
  parameter bit    REG_OUT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        WE,
  output logic        CS,
  output logic        iWE,
  output logic [31:0] iAddress
);
  logic  hit;
  addr_t off;
  addr_window_cmp #(.BASE(BASE_ADDR), .SIZE(WIN_SIZE)) u_cmp (
    .addr(addr),
    .hit (hit),
    .off (off)
  );
  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          CS       <= 1'b0;
          iWE      <= 1'b0;
          iAddress <= '0;
        end else begin
          CS       <= hit;
          iWE      <= WE & hit;
          iAddress <= off;
        end
      end
    end else begin : g_comb
      always_comb begin
        CS       = hit;
        iWE      = WE & hit;
        iAddress = off;
      end
    end
  endgenerate
endmodule

// File: tb/tb_addr_decoding.sv
// tb_addr_decoding: directed checks of the registered and combinational decoder builds
module tb_addr_decoding;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, addr_c;
  logic        we, we_c;
  logic        cs, iwe, cs_c, iwe_c;
  logic [31:0] iaddr, iaddr_c;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  addr_decoding #(.REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .WE(we),
    .CS(cs), .iWE(iwe), .iAddress(iaddr)
  );

  addr_decoding #(.REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .addr(addr_c), .WE(we_c),
    .CS(cs_c), .iWE(iwe_c), .iAddress(iaddr_c)
  );

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got cs=%b iwe=%b iaddr=%h, expected cs=%b iwe=%b iaddr=%h",
               tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic step(input logic rn, input logic [31:0] a, input logic w,
                      input logic c, input logic e, input logic [31:0] o, input string tag);
    rst_n = rn;
    addr  = a;
    we    = w;
    @(posedge clk);
    #1;
    check(tag, {cs, iwe, iaddr}, {c, e, o});
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; we = 1'b0; addr_c = '0; we_c = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 32'h1249, 1'b1, 1'b0, 1'b0, 32'h0,   "rst_c1");
    step(1'b0, 32'h1249, 1'b1, 1'b0, 1'b0, 32'h0,   "rst_c2");
    step(1'b1, 32'h1249, 1'b1, 1'b1, 1'b1, 32'h249, "rst_release");
    step(1'b1, 32'h205,  1'b0, 1'b0, 1'b0, 32'h0,   "miss_205_r");
    step(1'b1, 32'h205,  1'b1, 1'b0, 1'b0, 32'h0,   "miss_205_w");
    step(1'b1, 32'h24A,  1'b0, 1'b0, 1'b0, 32'h0,   "miss_24a_r");
    step(1'b1, 32'h24A,  1'b1, 1'b0, 1'b0, 32'h0,   "miss_24a_w");
    step(1'b1, 32'h1249, 1'b0, 1'b1, 1'b0, 32'h249, "hit_read");
    step(1'b1, 32'h1EE2, 1'b1, 1'b1, 1'b1, 32'hEE2, "hit_write");
    step(1'b1, 32'h0FFF, 1'b1, 1'b0, 1'b0, 32'h0,   "bnd_0fff");
    step(1'b1, 32'h1000, 1'b1, 1'b1, 1'b1, 32'h0,   "bnd_1000");
    step(1'b1, 32'h1FFF, 1'b1, 1'b1, 1'b1, 32'hFFF, "bnd_1fff");
    step(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0,   "bnd_2000");
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0, "bnd_ffffffff");
    step(1'b1, 32'h1004, 1'b1, 1'b1, 1'b1, 32'h4,   "mid_pre");
    step(1'b0, 32'h1008, 1'b1, 1'b0, 1'b0, 32'h0,   "mid_rst");
    step(1'b1, 32'h100C, 1'b1, 1'b1, 1'b1, 32'hC,   "mid_resume");
    step(1'b0, 32'hxxxx_xxxx, 1'b1, 1'b0, 1'b0, 32'h0, "rst_x_addr");
    rst_n = 1'b1; addr = 32'h1010; we = 1'b0;
    #1;
    check("latency_hold", {cs, iwe, iaddr}, {1'b0, 1'b0, 32'h0});
    addr_c = 32'h1EE2; we_c = 1'b1;
    #1;
    check("comb_hit", {cs_c, iwe_c, iaddr_c}, {1'b1, 1'b1, 32'hEE2});
    addr_c = 32'h2000;
    #1;
    check("comb_miss", {cs_c, iwe_c, iaddr_c}, {1'b0, 1'b0, 32'h0});
    addr_c = 32'h1000; we_c = 1'b0;
    #1;
    check("comb_read", {cs_c, iwe_c, iaddr_c}, {1'b1, 1'b0, 32'h0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
